// File: rtl/hi_sniff_pkg.sv
// Shared constants and types for the HF sniff frame scheduler.
package hi_sniff_pkg;

  localparam int SSP_FRAME_LEN  = 10;  // 8 data bits + 2 tag bits
  localparam int STARVE_DEFAULT = 4;

  localparam logic [1:0] TAG_ADC  = 2'd0;
  localparam logic [1:0] TAG_REQ1 = 2'd1;
  localparam logic [1:0] TAG_REQ2 = 2'd2;
  localparam logic [1:0] TAG_IDLE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // Two-way round-robin pick: returns the index of the winning requester.
  // With both candidates present, the preferred index (ptr) wins.
  function automatic logic rr_pick(input logic [1:0] cand, input logic ptr);
    if (&cand) return ptr;
    return ~cand[0];
  endfunction

endpackage

// File: rtl/hi_ssp_serializer.sv
// SSP frame serializer: slot counter, shift register, frame strobe and
// serial data. A frame word is loaded on the edge where load is high and
// its bit 0 is on ssp_din right after that edge.
module hi_ssp_serializer
  import hi_sniff_pkg::*;
#(
  parameter int FRAME_LEN = SSP_FRAME_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [FRAME_LEN-1:0] word,
  output logic                 last_slot,
  output logic                 ssp_frame,
  output logic                 ssp_din
);

  localparam int SLOT_W = $clog2(FRAME_LEN);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

  logic [SLOT_W-1:0]    slot_reg, slot_next;
  logic [FRAME_LEN-1:0] shift_reg, shift_next;
  logic                 active_reg, active_next;

  assign last_slot = active_reg && (slot_reg == LAST_SLOT);
  assign ssp_frame = active_reg && (slot_reg == '0);
  assign ssp_din   = active_reg && shift_reg[0];

  // Load a new word, or shift out the current one and stop after the last slot.
  always_comb begin
    slot_next   = slot_reg;
    shift_next  = shift_reg;
    active_next = active_reg;
    if (load) begin
      slot_next   = '0;
      shift_next  = word;
      active_next = 1'b1;
    end else if (active_reg) begin
      shift_next = shift_reg >> 1;
      if (last_slot) begin
        slot_next   = '0;
        active_next = 1'b0;
      end else begin
        slot_next = slot_reg + 1'b1;
      end
    end
  end

  // Serializer state register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_reg   <= '0;
      shift_reg  <= '0;
      active_reg <= 1'b0;
    end else begin
      slot_reg   <= slot_next;
      shift_reg  <= shift_next;
      active_reg <= active_next;
    end
  end

endmodule

// File: rtl/hi_sniff_sched.sv
// HF sniff frame scheduler: shares the SSP link between the decimated ADC
// stream and two external byte requesters, one tagged byte per frame.
// Optional macro HI_SNIFF_DROP_CNT_EN adds the saturating drop_cnt output.
module hi_sniff_sched
  import hi_sniff_pkg::*;
#(
  parameter int FRAME_LEN = SSP_FRAME_LEN,
  parameter int STARVE    = STARVE_DEFAULT
) (
  input  logic        ck_1356meg,
  input  logic        rst_n,
  input  logic        sniff_en,
  input  logic [3:0]  adc_div,
  input  logic [7:0]  adc_d,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic        adc_clk,
  output logic        ssp_clk,
  output logic        ssp_frame,
  output logic        ssp_din,
  output logic        drop_flag
`ifdef HI_SNIFF_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [7:0] STARVE_CNT = 8'(STARVE);

  sched_state_e state_reg, state_next;

  logic [3:0]      dcnt_reg, dcnt_next;
  logic            rr_ptr_reg, rr_ptr_next;
  logic            drop_flag_reg;
  logic [1:0][7:0] wait_reg, wait_next;

  logic            last_slot;
  logic            decide;
  logic            adc_due;
  logic [1:0]      starving;
  logic            grant_ext;
  logic            grant_idx;
  logic            use_adc;
  logic            drop;
  logic [9:0]      word;
  logic [3:0]      dcnt_reload;

  assign adc_clk   = ck_1356meg;
  assign ssp_clk   = ~ck_1356meg;
  assign drop_flag = drop_flag_reg;

  // A decision is only taken when a frame actually loads, so grants,
  // decimation and wait counting never happen for a frame that is not sent.
  assign decide  = sniff_en && ((state_reg == ST_IDLE) || last_slot);
  assign adc_due = (dcnt_reg == 4'd0) && (adc_div != 4'd0);

  // adc_div = 0 parks the counter at zero instead of wrapping to 15.
  assign dcnt_reload = (adc_div == 4'd0) ? 4'd0 : adc_div - 4'd1;

  // Per-requester starvation flag, grant strobe and wait counter update.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign starving[gi]  = req_valid[gi] && (wait_reg[gi] >= STARVE_CNT);
      assign req_ready[gi] = decide && grant_ext && (grant_idx == 1'(gi));
      assign wait_next[gi] = !req_valid[gi]              ? 8'd0 :
                             !decide                     ? wait_reg[gi] :
                             req_ready[gi]               ? 8'd0 :
                             (wait_reg[gi] >= STARVE_CNT) ? wait_reg[gi] :
                                                           wait_reg[gi] + 8'd1;
    end
  endgenerate

  // Source arbitration: starving requester, then due ADC sample, then
  // round-robin requester, then idle; also builds the frame word.
  always_comb begin
    grant_ext = 1'b0;
    grant_idx = 1'b0;
    use_adc   = 1'b0;
    drop      = 1'b0;
    if (|starving) begin
      grant_ext = 1'b1;
      grant_idx = rr_pick(starving, rr_ptr_reg);
      drop      = adc_due;
    end else if (adc_due) begin
      use_adc = 1'b1;
    end else if (|req_valid) begin
      grant_ext = 1'b1;
      grant_idx = rr_pick(req_valid, rr_ptr_reg);
    end

    if (grant_ext) begin
      word = grant_idx ? {TAG_REQ2, req_data[15:8]} : {TAG_REQ1, req_data[7:0]};
    end else if (use_adc) begin
      word = {TAG_ADC, adc_d};
    end else begin
      word = {TAG_IDLE, 8'h00};
    end
  end

  // Next-state logic for the run/idle FSM and decision-cycle counters.
  always_comb begin
    state_next  = state_reg;
    dcnt_next   = dcnt_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: if (sniff_en) state_next = ST_RUN;
      ST_RUN:  if (last_slot && !sniff_en) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (decide) begin
      dcnt_next = (dcnt_reg == 4'd0) ? dcnt_reload : dcnt_reg - 4'd1;
      if (grant_ext) rr_ptr_next = ~grant_idx;
    end
  end

  // State, decimation, round-robin, wait and sticky drop registers.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dcnt_reg      <= 4'd0;
      rr_ptr_reg    <= 1'b0;
      wait_reg      <= '0;
      drop_flag_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      dcnt_reg   <= dcnt_next;
      rr_ptr_reg <= rr_ptr_next;
      wait_reg   <= wait_next;
      if (decide && drop) drop_flag_reg <= 1'b1;
    end
  end

`ifdef HI_SNIFF_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  assign drop_cnt = drop_cnt_reg;

  // Saturating count of discarded ADC samples.
  always_ff @(posedge ck_1356meg) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else if (decide && drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end
`endif

  hi_ssp_serializer #(
    .FRAME_LEN (FRAME_LEN)
  ) u_ser (
    .clk       (ck_1356meg),
    .rst_n     (rst_n),
    .load      (decide),
    .word      (word),
    .last_slot (last_slot),
    .ssp_frame (ssp_frame),
    .ssp_din   (ssp_din)
  );

endmodule

// File: doc/hi_sniff_sched.md
# hi_sniff_sched

Frame scheduler for the HF sniff path. It shares the single SSP serial link to the ARM between three byte sources: the ADC sample stream (decimated) and two external byte requesters, e.g. the edge encoder and the marker injector. Each SSP frame carries one tagged byte. The block sits between the HF sniff front end and the SSP pins.

## Interface
Parameters:
- FRAME_LEN, 10: bits per SSP frame (8 data + 2 tag); fixed, not user-tunable.
- STARVE, 4: frames an external requester may wait before it preempts the ADC.

Ports:
- ck_1356meg  in  1  13.56 MHz clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- sniff_en  in  1  run enable; sampled only at frame boundaries.
- adc_div  in  4  ADC decimation. 0 = ADC source off; N = one sample every N frames.
- adc_d  in  8  ADC sample.
- req_valid  in  2  external requester valid, bit i = requester i+1.
- req_data  in  16  requester bytes; [7:0] = requester 1, [15:8] = requester 2.
- req_ready  out  2  one-cycle grant/accept.
- adc_clk  out  1  equals ck_1356meg.
- ssp_clk  out  1  equals ~ck_1356meg.
- ssp_frame  out  1  high during slot 0 of each frame.
- ssp_din  out  1  serial data, LSB first.
- drop_flag  out  1  sticky; set when an ADC sample is dropped.
- drop_cnt  out  8  dropped-sample count; present only with HI_SNIFF_DROP_CNT_EN.

## Operation
- Frame word is {tag[1:0], data[7:0]}, shifted out LSB first: data bits 0..7 in slots 0..7, then tag in slots 8..9.
- Tag values: 0 = ADC, 1 = requester 1, 2 = requester 2, 3 = idle (data 8'h00).
- States:
  - IDLE: ssp_frame = 0, ssp_din = 0, no grants.
  - RUN: slot counter runs 0..FRAME_LEN-1.
- Transitions:
  - IDLE→RUN: on the edge where sniff_en = 1; the first frame loads on that edge.
  - RUN, last slot, sniff_en = 1: the next frame loads.
  - RUN, last slot, sniff_en = 0: go to IDLE.
  - Deasserting sniff_en mid-frame always finishes the current frame.
- Arbitration is evaluated in the decision cycle, which is the IDLE cycle with sniff_en = 1 or the last RUN slot. Priority order:
  1. Any external requester with wait count ≥ STARVE. If both qualify, round-robin between them.
  2. ADC, if its sample is due.
  3. External requesters, round-robin. The requester not served last wins ties. The pointer updates only on an external grant.
  4. Idle frame.
- ADC due logic:
  - Decimation counter dcnt reloads to adc_div-1 when it is 0; otherwise it decrements. It is evaluated once per decision cycle.
  - The ADC is due when dcnt == 0 and adc_div != 0.
  - adc_div changes take effect at the next reload.
- Drop: a due ADC sample that loses to a starving requester is discarded, not deferred. drop_flag sets and stays set until reset.
- Wait counters, one per requester:
  - Increment (saturating at STARVE) at each decision cycle where valid = 1 and the requester is not granted.
  - Clear on grant, or when valid = 0.
- Handshake:
  - req_ready[i] is asserted combinationally in the decision cycle for the granted requester only. The transfer happens on that edge.
  - The requester must hold valid and data stable until ready is seen.
- ADC capture: adc_d is captured on the same edge that loads the frame.

## Timing
- Reset (rst_n = 0 at an edge): IDLE, slot = 0, ssp_frame = 0, ssp_din = 0, req_ready = 0, drop_flag = 0, drop_cnt = 0, dcnt = 0, wait counters = 0, RR pointer = requester 1. Reset mid-frame aborts the frame immediately.
- Latency:
  - req_ready to first data bit on ssp_din: 1 cycle.
  - adc_d capture to bit 0 on the line: 0 cycles after the capture edge.
- Throughput: one frame per FRAME_LEN cycles, back-to-back, no gap.
- Data changes on rising ck_1356meg, which is the falling edge of ssp_clk.

## Configuration
- HI_SNIFF_DROP_CNT_EN defined: drop_cnt is present. It increments on each dropped sample and saturates at 8'hFF.
- Not defined: drop_cnt port and counter are absent; drop_flag only.

## Structure
- Package hi_sniff_pkg:
  - Tag constants TAG_ADC, TAG_REQ1, TAG_REQ2, TAG_IDLE.
  - FRAME_LEN.
  - Default STARVE.
- Sub-module hi_ssp_serializer: slot counter, 10-bit shift register, ssp_frame/ssp_din generation. Inputs are load and word; output is last_slot.
- The arbiter, decimation counter and wait counters stay in the top level.

## Test plan
- adc_div = 1, no requests, adc_d = 8'hA5, sniff_en = 1 → every 10 cycles a frame with ssp_frame on slot 0 and bits 1,0,1,0,0,1,0,1,0,0 (tag 0).
- adc_div = 0, req_valid = 2'b11, data 8'h11 / 8'h22 → frames alternate tag 1 / tag 2, each req_ready one cycle.
- adc_div = 1, req_valid[0] held → frames 1–4 are ADC, frame 5 is requester 1 (tag 1), drop_flag = 1, drop_cnt = 1.
- No sources, sniff_en = 1 → idle frames with tag 3, data 0.
- sniff_en dropped at slot 3 → frame completes through slot 9, then IDLE with ssp_din = 0. rst_n pulsed at slot 5 of a later frame → outputs are 0 the next cycle.
- adc_div changed from 3 to 2 mid-cycle → old spacing holds until reload, then one ADC frame every 2 frames.
